// File: rtl/viterbi_pkg.sv
// ============================================================================
// Module      : viterbi_pkg
// Description : Shared constants, types and trellis helpers for the K=3,
//               rate-1/2 convolutional encoder and Viterbi decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package viterbi_pkg;

    localparam int             K        = 3;
    localparam logic [K-1:0]   G0       = 3'o7;
    localparam logic [K-1:0]   G1       = 3'o5;
    localparam int             DEPTH    = 32;
    localparam int             METRIC_W = 6;

    typedef logic [1:0]          state_t;
    typedef logic [METRIC_W-1:0] metric_t;

    // Code symbol {c0,c1} emitted when input u leaves encoder state s={s1,s2}.
    function automatic logic [1:0] branch_sym(input logic u, input state_t s);
        logic [K-1:0] w_taps;
        w_taps = {u, s};
        return {^(w_taps & G0), ^(w_taps & G1)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] w_x;
        w_x = a ^ b;
        return {1'b0, w_x[1]} + {1'b0, w_x[0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/viterbi_tx_rx_conv_encoder.sv
// ============================================================================
// Module      : conv_encoder
// Description : K=3 rate-1/2 convolutional encoder with registered symbol
//               and valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_encoder
    import viterbi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [1:0] o_sym,
    output logic       o_valid
);

    state_t     r_state;
    logic [1:0] r_sym;
    logic       r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= 2'b00;
            r_sym   <= 2'b00;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_sym   <= branch_sym(i_bit, r_state);
            r_state <= {i_bit, r_state[1]};
            r_valid <= 1'b1;
        end
    end

    assign o_sym   = r_sym;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/viterbi_tx_rx.sv
// ============================================================================
// Module      : viterbi_tx_rx
// Description : Encoder plus 4-state register-exchange Viterbi decoder over a
//               noiseless internal channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module viterbi_tx_rx
    import viterbi_pkg::*;
#(
    parameter int DEPTH    = viterbi_pkg::DEPTH,
    parameter int METRIC_W = viterbi_pkg::METRIC_W
) (
    input  logic clk,
    input  logic rst,
    input  logic encoder_i,
    input  logic enable_encoder_i,
    output logic decoder_o
);

    localparam logic [METRIC_W-1:0] C_MAX = {METRIC_W{1'b1}};

    logic [1:0]          w_sym;
    logic                w_valid;

    logic [METRIC_W-1:0] r_metric [4];
    logic [DEPTH-1:0]    r_surv   [4];
    logic                r_pick;
    logic                r_dec_out;

    logic [METRIC_W+1:0] w_acs      [4];
    logic [METRIC_W-1:0] w_metric_n [4];
    logic [DEPTH-1:0]    w_surv_n   [4];
    logic [3:0]          w_dec;
    logic [METRIC_W+1:0] w_min;
    state_t              w_best;

    conv_encoder u_enc (
        .clk     (clk),
        .rst     (rst),
        .i_en    (enable_encoder_i),
        .i_bit   (encoder_i),
        .o_sym   (w_sym),
        .o_valid (w_valid)
    );

    // New state {u,a} is reached from {a,0} and {a,1}; {a,0} wins ties.
    for (genvar gs = 0; gs < 4; gs++) begin : g_acs
        localparam state_t c_ns = state_t'(gs);
        localparam logic   c_u  = c_ns[1];
        localparam state_t c_p0 = {c_ns[0], 1'b0};
        localparam state_t c_p1 = {c_ns[0], 1'b1};

        logic [METRIC_W+1:0] w_sum0;
        logic [METRIC_W+1:0] w_sum1;
        logic [DEPTH-1:0]    w_sel;

        assign w_sum0 = {2'b00, r_metric[c_p0]}
                      + {{METRIC_W{1'b0}}, hamming2(w_sym, branch_sym(c_u, c_p0))};
        assign w_sum1 = {2'b00, r_metric[c_p1]}
                      + {{METRIC_W{1'b0}}, hamming2(w_sym, branch_sym(c_u, c_p1))};
        assign w_dec[gs]    = (w_sum1 < w_sum0);
        assign w_acs[gs]    = w_dec[gs] ? w_sum1 : w_sum0;
        assign w_sel        = w_dec[gs] ? r_surv[c_p1] : r_surv[c_p0];
        assign w_surv_n[gs] = {w_sel[DEPTH-2:0], c_u};
    end

    always_comb begin
        w_min = w_acs[0];
        for (int i = 1; i < 4; i++) begin
            if (w_acs[i] < w_min) begin
                w_min = w_acs[i];
            end
        end
    end

    for (genvar gn = 0; gn < 4; gn++) begin : g_norm
        logic [METRIC_W+1:0] w_diff;
        assign w_diff          = w_acs[gn] - w_min;
        assign w_metric_n[gn]  = (w_diff > {2'b00, C_MAX}) ? C_MAX : w_diff[METRIC_W-1:0];
    end

    // Strict compare keeps the lowest index on metric ties.
    always_comb begin
        w_best = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (r_metric[i] < r_metric[w_best]) begin
                w_best = state_t'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_metric[0] <= '0;
            r_metric[1] <= C_MAX;
            r_metric[2] <= C_MAX;
            r_metric[3] <= C_MAX;
            for (int i = 0; i < 4; i++) begin
                r_surv[i] <= '0;
            end
            r_pick    <= 1'b0;
            r_dec_out <= 1'b0;
        end else if (enable_encoder_i) begin
            if (w_valid) begin
                for (int i = 0; i < 4; i++) begin
                    r_metric[i] <= w_metric_n[i];
                    r_surv[i]   <= w_surv_n[i];
                end
            end
            r_pick    <= r_surv[w_best][DEPTH-1];
            r_dec_out <= r_pick;
        end
    end

    assign decoder_o = r_dec_out;

endmodule

`default_nettype wire

// File: tb/tb_viterbi_tx_rx.sv
// ============================================================================
// Module      : tb_viterbi_tx_rx
// Description : Directed/random bench with a delay-line reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_viterbi_tx_rx;

    localparam int DEPTH    = 32;
    localparam int METRIC_W = 6;
    localparam int LAT      = DEPTH + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic encoder_i = 1'b0;
    logic enable_encoder_i = 1'b0;
    logic decoder_o;

    int   vectors    = 0;
    int   miscompares = 0;

    logic hist[$];
    int   e_cnt;
    logic last_exp;
    logic ms1, ms2;

    viterbi_tx_rx #(.DEPTH(DEPTH), .METRIC_W(METRIC_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .encoder_i        (encoder_i),
        .enable_encoder_i (enable_encoder_i),
        .decoder_o        (decoder_o)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        hist.delete();
        e_cnt    = 0;
        last_exp = 1'b0;
        ms1      = 1'b0;
        ms2      = 1'b0;
    endtask

    // Reference: output is the input delayed by LAT enabled edges, zero before that.
    task automatic tick(input logic u, input logic en, input string tag);
        logic       exp_o;
        logic [1:0] exp_sym;
        encoder_i        = u;
        enable_encoder_i = en;
        @(posedge clk);
        #1;
        if (en) begin
            exp_sym = {u ^ ms1 ^ ms2, u ^ ms2};
            ms2 = ms1;
            ms1 = u;
            hist.push_back(u);
            exp_o = (e_cnt >= LAT) ? hist[e_cnt - LAT] : 1'b0;
            e_cnt++;
            vectors++;
            assert (dut.u_enc.o_sym === exp_sym) else begin
                miscompares++;
                $error("FAIL %s_sym edge=%0d observed=%b expected=%b", tag, e_cnt, dut.u_enc.o_sym, exp_sym);
            end
        end else begin
            exp_o = last_exp;
        end
        last_exp = exp_o;
        vectors++;
        assert (decoder_o === exp_o) else begin
            miscompares++;
            $error("FAIL %s_out edge=%0d observed=%b expected=%b", tag, e_cnt, decoder_o, exp_o);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        vectors++;
        assert (decoder_o === 1'b0) else begin
            miscompares++;
            $error("FAIL %s_rst observed=%b expected=0", tag, decoder_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [30:0] pat;
        logic [3:0]  seq4;
        pat  = 31'b1001100011100001111000001111101;
        seq4 = 4'b1001;
        model_clear();

        // Reset state and all-zero input.
        do_reset("por");
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, "zeros");

        // 1,0,0,1 from reset, then zeros until it emerges.
        do_reset("seq4");
        for (int i = 3; i >= 0; i--) tick(seq4[i], 1'b1, "seq4");
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, "seq4");

        // Pattern twice, then ones with single-cycle zero pulses.
        do_reset("pat");
        for (int r = 0; r < 2; r++)
            for (int i = 30; i >= 0; i--) tick(pat[i], 1'b1, "pat");
        for (int i = 1; i <= 300; i++) tick((i % 100) != 0, 1'b1, "pulse");

        // Random stream with a 10-cycle stall in the middle.
        for (int i = 0; i < 50; i++) tick(1'($urandom), 1'b1, "pre_stall");
        for (int i = 0; i < 10; i++) tick(1'($urandom), 1'b0, "stall");
        for (int i = 0; i < 50; i++) tick(1'($urandom), 1'b1, "post_stall");

        // Mid-stream reset.
        do_reset("mid");
        for (int i = 0; i < 80; i++) tick(1'($urandom), 1'b1, "after_rst");

        // Long all-ones run.
        do_reset("ones");
        for (int i = 0; i < 1000; i++) tick(1'b1, 1'b1, "ones");

        // Random data with random enables.
        for (int i = 0; i < 300; i++) tick(1'($urandom), $urandom_range(0, 3) != 0, "rand_en");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
